// File: rtl/shot_slot_scheduler_pkg.sv
// Shared constants for the projectile slot scheduler: owner encoding,
// owner field width and default shot timing.
package shot_slot_scheduler_pkg;

  localparam int unsigned OWN_W        = 3;
  localparam int unsigned LIFE_W       = 8;
  localparam int unsigned DEF_LIFETIME = 60;
  localparam int unsigned DEF_COOLDOWN = 8;

  localparam logic [OWN_W-1:0] OWN_TANK     = 3'd0;
  localparam logic [OWN_W-1:0] OWN_MON_BASE = 3'd1;

  function automatic logic [OWN_W-1:0] mon_owner(input int unsigned k);
    return OWN_MON_BASE + OWN_W'(k);
  endfunction

endpackage

// File: rtl/shot_slot_scheduler_rr.sv
// Round-robin one-hot picker: first set request at or after ptr_i, wrapping.
module shot_rr_arbiter #(
  parameter int unsigned N     = 5,
  parameter int unsigned PTR_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]     req_i,
  input  logic [PTR_W-1:0] ptr_i,
  output logic [N-1:0]     gnt_o,
  output logic             valid_o
);

  int unsigned idx;

  always_comb begin
    gnt_o   = '0;
    valid_o = 1'b0;
    idx     = 0;
    for (int unsigned i = 0; i < N; i++) begin
      idx = (int'(ptr_i) + i) % N;
      if (!valid_o && req_i[idx]) begin
        gnt_o[idx] = 1'b1;
        valid_o    = 1'b1;
      end
    end
  end

endmodule

// File: rtl/shot_slot_scheduler.sv
// Projectile slot pool shared between the tank and the monsters: grants,
// owner tagging, per-frame aging, hit/expiry release and tank fire queuing.
module shot_slot_scheduler
  import shot_slot_scheduler_pkg::*;
#(
  parameter int unsigned NUM_SLOTS = 4,
  parameter int unsigned NUM_MON   = 5,
  parameter int unsigned LIFETIME  = DEF_LIFETIME,
  parameter int unsigned COOLDOWN  = DEF_COOLDOWN,
  parameter int unsigned TANK_MAX  = 2
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       frame_tick,
  input  logic                       enable,
  input  logic                       clear,
  input  logic                       tank_fire,
  input  logic [NUM_MON-1:0]         mon_req,
  input  logic [NUM_SLOTS-1:0]       hit,
  output logic [NUM_SLOTS-1:0]       slot_active,
  output logic [OWN_W*NUM_SLOTS-1:0] slot_owner,
  output logic [NUM_SLOTS-1:0]       launch,
  output logic                       grant_tank,
  output logic [NUM_MON-1:0]         grant_mon,
  output logic [NUM_SLOTS-1:0]       expire,
  output logic [2:0]                 free_count
);

  localparam int unsigned PTR_W  = (NUM_MON > 1) ? $clog2(NUM_MON) : 1;
  localparam int unsigned SLOT_W = (NUM_SLOTS > 1) ? $clog2(NUM_SLOTS) : 1;

  logic [NUM_SLOTS-1:0]             active_q, active_d;
  logic [NUM_SLOTS-1:0][OWN_W-1:0]  owner_q, owner_d;
  logic [NUM_SLOTS-1:0][LIFE_W-1:0] life_q, life_d;
  logic [NUM_SLOTS-1:0]             launch_q, launch_d;
  logic [NUM_SLOTS-1:0]             expire_q, expire_d;
  logic [LIFE_W-1:0]                cool_q, cool_d;
  logic                             pend_q, pend_d;
  logic [PTR_W-1:0]                 rr_q, rr_d;
  logic                             gtank_q, gtank_d;
  logic [NUM_MON-1:0]               gmon_q, gmon_d;
  logic [2:0]                       free_q, free_d;

  logic [SLOT_W-1:0]  cand;
  logic               slot_avail;
  int unsigned        tank_cnt;
  int unsigned        act_cnt;
  logic [NUM_MON-1:0] mon_busy;
  logic [NUM_MON-1:0] mon_elig;
  logic [NUM_MON-1:0] mon_gnt;
  logic               mon_valid;
  logic [PTR_W-1:0]   mon_idx;
  logic               aging;
  logic               tank_win;

  // Candidate slot and ownership summaries come only from registered state,
  // so a slot freed at this edge can never also be granted at this edge.
  always_comb begin
    cand       = '0;
    slot_avail = 1'b0;
    tank_cnt   = 0;
    mon_busy   = '0;
    for (int unsigned s = 0; s < NUM_SLOTS; s++) begin
      if (!active_q[s] && !slot_avail) begin
        cand       = SLOT_W'(s);
        slot_avail = 1'b1;
      end
      if (active_q[s] && owner_q[s] == OWN_TANK) tank_cnt++;
      for (int unsigned k = 0; k < NUM_MON; k++) begin
        if (active_q[s] && owner_q[s] == mon_owner(k)) mon_busy[k] = 1'b1;
      end
    end
  end

  assign mon_elig = mon_req & ~mon_busy;

  shot_rr_arbiter #(
    .N     (NUM_MON),
    .PTR_W (PTR_W)
  ) u_mon_arb (
    .req_i   (mon_elig),
    .ptr_i   (rr_q),
    .gnt_o   (mon_gnt),
    .valid_o (mon_valid)
  );

  always_comb begin
    mon_idx = '0;
    for (int unsigned k = 0; k < NUM_MON; k++) begin
      if (mon_gnt[k]) mon_idx = PTR_W'(k);
    end
  end

  assign aging    = frame_tick & enable;
  assign tank_win = (tank_fire | pend_q) && (cool_q == '0) &&
                    (tank_cnt < TANK_MAX) && slot_avail;

  always_comb begin
    active_d = active_q;
    owner_d  = owner_q;
    life_d   = life_q;
    launch_d = '0;
    expire_d = '0;
    cool_d   = cool_q;
    pend_d   = pend_q;
    rr_d     = rr_q;
    gtank_d  = 1'b0;
    gmon_d   = '0;
    free_d   = free_q;
    act_cnt  = 0;

    if (clear) begin
      active_d = '0;
      owner_d  = '0;
      life_d   = '0;
      cool_d   = '0;
      pend_d   = 1'b0;
      rr_d     = '0;
    end else begin
      // A hit takes priority over expiry, so a simultaneous age-out is silent.
      for (int unsigned s = 0; s < NUM_SLOTS; s++) begin
        if (active_q[s]) begin
          if (hit[s]) begin
            active_d[s] = 1'b0;
            life_d[s]   = '0;
          end else if (aging) begin
            if (life_q[s] == LIFE_W'(1)) begin
              active_d[s] = 1'b0;
              expire_d[s] = 1'b1;
              life_d[s]   = '0;
            end else begin
              life_d[s] = life_q[s] - LIFE_W'(1);
            end
          end
        end
      end

      if (aging && cool_q != '0) cool_d = cool_q - LIFE_W'(1);

      if (enable) begin
        if (tank_win) begin
          active_d[cand] = 1'b1;
          owner_d[cand]  = OWN_TANK;
          life_d[cand]   = LIFE_W'(LIFETIME);
          launch_d[cand] = 1'b1;
          gtank_d        = 1'b1;
          cool_d         = LIFE_W'(COOLDOWN);
          pend_d         = 1'b0;
        end else begin
          if (tank_fire && cool_q == '0) pend_d = 1'b1;
          if (mon_valid && slot_avail) begin
            active_d[cand] = 1'b1;
            owner_d[cand]  = mon_owner(int'(mon_idx));
            life_d[cand]   = LIFE_W'(LIFETIME);
            launch_d[cand] = 1'b1;
            gmon_d         = mon_gnt;
            rr_d           = (mon_idx == PTR_W'(NUM_MON - 1)) ? '0 : mon_idx + PTR_W'(1);
          end
        end
      end
    end

    for (int unsigned s = 0; s < NUM_SLOTS; s++) begin
      if (active_d[s]) act_cnt++;
    end
    free_d = 3'(NUM_SLOTS - act_cnt);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      active_q <= '0;
      owner_q  <= '0;
      life_q   <= '0;
      launch_q <= '0;
      expire_q <= '0;
      cool_q   <= '0;
      pend_q   <= 1'b0;
      rr_q     <= '0;
      gtank_q  <= 1'b0;
      gmon_q   <= '0;
      free_q   <= 3'(NUM_SLOTS);
    end else begin
      active_q <= active_d;
      owner_q  <= owner_d;
      life_q   <= life_d;
      launch_q <= launch_d;
      expire_q <= expire_d;
      cool_q   <= cool_d;
      pend_q   <= pend_d;
      rr_q     <= rr_d;
      gtank_q  <= gtank_d;
      gmon_q   <= gmon_d;
      free_q   <= free_d;
    end
  end

  assign slot_active = active_q;
  assign slot_owner  = owner_q;
  assign launch      = launch_q;
  assign grant_tank  = gtank_q;
  assign grant_mon   = gmon_q;
  assign expire      = expire_q;
  assign free_count  = free_q;

endmodule

// File: tb/tb_shot_slot_scheduler.sv
// Directed bench for shot_slot_scheduler: vector table plus hand sequences
// for lifetime expiry, hit/expiry collision, clear and asynchronous reset.
module tb_shot_slot_scheduler;

  logic        clk;
  logic        rst;
  logic        frame_tick;
  logic        enable;
  logic        clear;
  logic        tank_fire;
  logic [4:0]  mon_req;
  logic [3:0]  hit;
  logic [3:0]  slot_active;
  logic [11:0] slot_owner;
  logic [3:0]  launch;
  logic        grant_tank;
  logic [4:0]  grant_mon;
  logic [3:0]  expire;
  logic [2:0]  free_count;

  int n_cmp = 0;
  int n_err = 0;

  shot_slot_scheduler #(
    .NUM_SLOTS (4),
    .NUM_MON   (5),
    .LIFETIME  (60),
    .COOLDOWN  (8),
    .TANK_MAX  (2)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .frame_tick  (frame_tick),
    .enable      (enable),
    .clear       (clear),
    .tank_fire   (tank_fire),
    .mon_req     (mon_req),
    .hit         (hit),
    .slot_active (slot_active),
    .slot_owner  (slot_owner),
    .launch      (launch),
    .grant_tank  (grant_tank),
    .grant_mon   (grant_mon),
    .expire      (expire),
    .free_count  (free_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        fire;
    logic [4:0]  mon;
    logic [3:0]  hit;
    logic        tick;
    logic        en;
    logic        clr;
    logic [3:0]  act;
    logic [3:0]  lau;
    logic        gt;
    logic [4:0]  gm;
    logic [3:0]  exp;
    logic [2:0]  fc;
    logic [11:0] own;
  } vec_t;

  vec_t tbl [23];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, req);
    end
  endtask

  task automatic cyc(input logic f, input logic [4:0] m, input logic [3:0] h,
                     input logic t, input logic e, input logic c);
    tank_fire  = f;
    mon_req    = m;
    hit        = h;
    frame_tick = t;
    enable     = e;
    clear      = c;
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    cyc(1'b0, 5'b0, 4'b0, 1'b0, 1'b1, 1'b0);
  endtask

  task automatic tick();
    cyc(1'b0, 5'b0, 4'b0, 1'b1, 1'b1, 1'b0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [11:0] mask;

    // fire, mon, hit, tick, en, clr | act, launch, gtank, gmon, expire, free, owner
    tbl[0]  = '{1'b1, 5'b00000, 4'b0000, 1'b0, 1'b1, 1'b0, 4'b0001, 4'b0001, 1'b1, 5'b00000, 4'b0, 3'd3, 12'h000};
    tbl[1]  = '{1'b0, 5'b00000, 4'b0000, 1'b1, 1'b1, 1'b0, 4'b0001, 4'b0000, 1'b0, 5'b00000, 4'b0, 3'd3, 12'h000};
    tbl[2]  = '{1'b0, 5'b00000, 4'b0000, 1'b1, 1'b1, 1'b0, 4'b0001, 4'b0000, 1'b0, 5'b00000, 4'b0, 3'd3, 12'h000};
    tbl[3]  = '{1'b0, 5'b00000, 4'b0000, 1'b1, 1'b1, 1'b0, 4'b0001, 4'b0000, 1'b0, 5'b00000, 4'b0, 3'd3, 12'h000};
    tbl[4]  = '{1'b1, 5'b00000, 4'b0000, 1'b0, 1'b1, 1'b0, 4'b0001, 4'b0000, 1'b0, 5'b00000, 4'b0, 3'd3, 12'h000};
    tbl[5]  = '{1'b0, 5'b00000, 4'b0000, 1'b1, 1'b1, 1'b0, 4'b0001, 4'b0000, 1'b0, 5'b00000, 4'b0, 3'd3, 12'h000};
    tbl[6]  = '{1'b0, 5'b00000, 4'b0000, 1'b1, 1'b1, 1'b0, 4'b0001, 4'b0000, 1'b0, 5'b00000, 4'b0, 3'd3, 12'h000};
    tbl[7]  = '{1'b0, 5'b00000, 4'b0000, 1'b1, 1'b1, 1'b0, 4'b0001, 4'b0000, 1'b0, 5'b00000, 4'b0, 3'd3, 12'h000};
    tbl[8]  = '{1'b0, 5'b00000, 4'b0000, 1'b1, 1'b1, 1'b0, 4'b0001, 4'b0000, 1'b0, 5'b00000, 4'b0, 3'd3, 12'h000};
    tbl[9]  = '{1'b0, 5'b00000, 4'b0000, 1'b1, 1'b1, 1'b0, 4'b0001, 4'b0000, 1'b0, 5'b00000, 4'b0, 3'd3, 12'h000};
    tbl[10] = '{1'b1, 5'b00000, 4'b0000, 1'b0, 1'b1, 1'b0, 4'b0011, 4'b0010, 1'b1, 5'b00000, 4'b0, 3'd2, 12'h000};
    tbl[11] = '{1'b0, 5'b00000, 4'b0000, 1'b0, 1'b1, 1'b1, 4'b0000, 4'b0000, 1'b0, 5'b00000, 4'b0, 3'd4, 12'h000};
    tbl[12] = '{1'b0, 5'b11111, 4'b0000, 1'b0, 1'b1, 1'b0, 4'b0001, 4'b0001, 1'b0, 5'b00001, 4'b0, 3'd3, 12'h001};
    tbl[13] = '{1'b0, 5'b11111, 4'b0000, 1'b0, 1'b1, 1'b0, 4'b0011, 4'b0010, 1'b0, 5'b00010, 4'b0, 3'd2, 12'h011};
    tbl[14] = '{1'b0, 5'b11111, 4'b0000, 1'b0, 1'b1, 1'b0, 4'b0111, 4'b0100, 1'b0, 5'b00100, 4'b0, 3'd1, 12'h0D1};
    tbl[15] = '{1'b0, 5'b11111, 4'b0000, 1'b0, 1'b1, 1'b0, 4'b1111, 4'b1000, 1'b0, 5'b01000, 4'b0, 3'd0, 12'h8D1};
    tbl[16] = '{1'b0, 5'b11111, 4'b0000, 1'b0, 1'b1, 1'b0, 4'b1111, 4'b0000, 1'b0, 5'b00000, 4'b0, 3'd0, 12'h8D1};
    tbl[17] = '{1'b0, 5'b11111, 4'b0100, 1'b0, 1'b1, 1'b0, 4'b1011, 4'b0000, 1'b0, 5'b00000, 4'b0, 3'd1, 12'h811};
    tbl[18] = '{1'b0, 5'b11111, 4'b0000, 1'b0, 1'b1, 1'b0, 4'b1111, 4'b0100, 1'b0, 5'b10000, 4'b0, 3'd0, 12'h951};
    tbl[19] = '{1'b1, 5'b00000, 4'b0000, 1'b0, 1'b1, 1'b0, 4'b1111, 4'b0000, 1'b0, 5'b00000, 4'b0, 3'd0, 12'h951};
    tbl[20] = '{1'b0, 5'b00000, 4'b0010, 1'b0, 1'b1, 1'b0, 4'b1101, 4'b0000, 1'b0, 5'b00000, 4'b0, 3'd1, 12'h941};
    tbl[21] = '{1'b0, 5'b00000, 4'b0000, 1'b0, 1'b1, 1'b0, 4'b1111, 4'b0010, 1'b1, 5'b00000, 4'b0, 3'd0, 12'h941};
    tbl[22] = '{1'b0, 5'b00000, 4'b0000, 1'b0, 1'b1, 1'b1, 4'b0000, 4'b0000, 1'b0, 5'b00000, 4'b0, 3'd4, 12'h000};

    rst = 1'b0;
    tank_fire = 1'b0; mon_req = '0; hit = '0; frame_tick = 1'b0; enable = 1'b0; clear = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst active", 32'(slot_active), 32'h0);
    chk("rst free",   32'(free_count),  32'd4);
    chk("rst launch", 32'(launch),      32'h0);
    chk("rst gtank",  32'(grant_tank),  32'h0);
    chk("rst gmon",   32'(grant_mon),   32'h0);
    chk("rst expire", 32'(expire),      32'h0);
    chk("rst owner",  32'(slot_owner),  32'h0);
    @(negedge clk);
    rst = 1'b1;

    for (int i = 0; i < 23; i++) begin
      cyc(tbl[i].fire, tbl[i].mon, tbl[i].hit, tbl[i].tick, tbl[i].en, tbl[i].clr);
      mask = '0;
      for (int s = 0; s < 4; s++) if (tbl[i].act[s]) mask[3*s +: 3] = 3'b111;
      chk($sformatf("v%0d active", i), 32'(slot_active), 32'(tbl[i].act));
      chk($sformatf("v%0d launch", i), 32'(launch),      32'(tbl[i].lau));
      chk($sformatf("v%0d gtank",  i), 32'(grant_tank),  32'(tbl[i].gt));
      chk($sformatf("v%0d gmon",   i), 32'(grant_mon),   32'(tbl[i].gm));
      chk($sformatf("v%0d expire", i), 32'(expire),      32'(tbl[i].exp));
      chk($sformatf("v%0d free",   i), 32'(free_count),  32'(tbl[i].fc));
      chk($sformatf("v%0d owner",  i), 32'(slot_owner & mask), 32'(tbl[i].own));
    end

    // Lifetime: expiry after exactly 60 enabled frame ticks; a disabled tick holds life.
    cyc(1'b1, 5'b0, 4'b0, 1'b0, 1'b1, 1'b0);
    chk("life launch", 32'(launch), 32'h1);
    for (int i = 1; i <= 59; i++) begin
      tick();
      if (slot_active !== 4'b0001 || expire !== 4'b0000)
        chk($sformatf("life tick%0d", i), 32'({slot_active, expire}), 32'h10);
      if (i == 30) begin
        cyc(1'b0, 5'b0, 4'b0, 1'b1, 1'b0, 1'b0);
        chk("life hold en0", 32'(slot_active), 32'h1);
      end
    end
    chk("life tick59 active", 32'(slot_active), 32'h1);
    chk("life tick59 expire", 32'(expire),      32'h0);
    tick();
    chk("life tick60 expire", 32'(expire),      32'h1);
    chk("life tick60 active", 32'(slot_active), 32'h0);
    chk("life tick60 free",   32'(free_count),  32'd4);
    idle();
    chk("life expire pulse", 32'(expire), 32'h0);

    // Hit and the 60th tick on the same edge: freed silently.
    cyc(1'b1, 5'b0, 4'b0, 1'b0, 1'b1, 1'b0);
    chk("hitexp launch", 32'(launch), 32'h1);
    repeat (59) tick();
    cyc(1'b0, 5'b0, 4'b0001, 1'b1, 1'b1, 1'b0);
    chk("hitexp active", 32'(slot_active), 32'h0);
    chk("hitexp expire", 32'(expire),      32'h0);
    idle();
    chk("hitexp expire late", 32'(expire), 32'h0);

    // TANK_MAX blocks a third tank shot; clear then drops the queued fire.
    cyc(1'b1, 5'b0, 4'b0, 1'b0, 1'b1, 1'b0);
    chk("tmax g1", 32'({grant_tank, slot_active}), 32'h11);
    repeat (8) tick();
    cyc(1'b1, 5'b0, 4'b0, 1'b0, 1'b1, 1'b0);
    chk("tmax g2", 32'({grant_tank, launch, slot_active}), 32'h123);
    repeat (8) tick();
    cyc(1'b0, 5'b00001, 4'b0, 1'b0, 1'b1, 1'b0);
    chk("tmax mon", 32'({grant_mon, slot_active}), 32'h17);
    cyc(1'b1, 5'b0, 4'b0, 1'b0, 1'b1, 1'b0);
    chk("tmax blocked", 32'({grant_tank, slot_active}), 32'h07);
    idle();
    chk("tmax still blocked", 32'({grant_tank, slot_active}), 32'h07);
    cyc(1'b0, 5'b0, 4'b0, 1'b0, 1'b1, 1'b1);
    chk("clear active", 32'(slot_active), 32'h0);
    chk("clear free",   32'(free_count),  32'd4);
    idle();
    chk("clear pending dropped", 32'({grant_tank, slot_active}), 32'h0);

    // Asynchronous reset in mid-cycle.
    cyc(1'b1, 5'b0, 4'b0, 1'b0, 1'b1, 1'b0);
    chk("arst pre", 32'(slot_active), 32'h1);
    @(negedge clk);
    #2;
    rst = 1'b0;
    #1;
    chk("arst active", 32'(slot_active), 32'h0);
    chk("arst free",   32'(free_count),  32'd4);
    chk("arst gtank",  32'(grant_tank),  32'h0);
    @(negedge clk);
    rst = 1'b1;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
